// File: rtl/core_lsu_pkg.sv
// Shared LSU definitions: access-size encodings, trap causes and the
// response-queue entry layout.
package core_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_SZ_B = 2'd0,
    LSU_SZ_H = 2'd1,
    LSU_SZ_W = 2'd2,
    LSU_SZ_D = 2'd3
  } lsu_size_e;

  localparam logic [5:0] TRAP_LDACCESS = 6'd5;
  localparam logic [5:0] TRAP_STACCESS = 6'd7;

  // Entries are sized for the widest core; narrower builds use the low bits.
  localparam int LSU_MAX_XLEN = 64;
  localparam int LSU_MAX_RD_W = 5;

  typedef struct packed {
    logic                    load;
    logic                    store;
    lsu_size_e               size;
    logic                    sext;
    logic [LSU_MAX_RD_W-1:0] rd;
    logic [LSU_MAX_XLEN-1:0] addr;
    logic                    done;
    logic                    err;
    logic                    kill;
    logic [LSU_MAX_XLEN-1:0] data;
  } lsu_q_entry_t;

endpackage

// File: rtl/core_lsu_rsp_q_if.sv
// Bus between the LSU request/response side and the writeback stage.
// wb_valid/wb_ready: a result transfers on any cycle both are high; while
// wb_valid is high and wb_ready low the wb_* fields hold steady.
interface core_lsu_rsp_q_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
);
  logic                  req_fire;
  logic                  req_ready;
  logic                  req_load;
  logic                  req_store;
  logic [1:0]            req_size;
  logic                  req_sext;
  logic [REG_ADDR_W-1:0] req_rd;
  logic [XLEN-1:0]       req_addr;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [XLEN-1:0]       rsp_rdata;
  logic                  wb_valid;
  logic                  wb_ready;
  logic                  wb_rd_wen;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_rdata;
  logic                  wb_trap;
  logic [5:0]            wb_cause;
  logic [XLEN-1:0]       wb_mtval;

  modport master (
    output req_fire, req_load, req_store, req_size, req_sext, req_rd, req_addr,
    output rsp_valid, rsp_err, rsp_rdata, wb_ready,
    input  req_ready, wb_valid, wb_rd_wen, wb_rd, wb_rdata, wb_trap, wb_cause, wb_mtval
  );

  modport slave (
    input  req_fire, req_load, req_store, req_size, req_sext, req_rd, req_addr,
    input  rsp_valid, rsp_err, rsp_rdata, wb_ready,
    output req_ready, wb_valid, wb_rd_wen, wb_rd, wb_rdata, wb_trap, wb_cause, wb_mtval
  );
endinterface

// File: rtl/core_lsu_align.sv
// Load-data alignment: shift the addressed bytes down, then zero- or
// sign-fill above the access width.
module core_lsu_align
  import core_lsu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  i_data,
  input  logic [OFF_W-1:0] i_off,
  input  lsu_size_e        i_size,
  input  logic             i_sext,
  output logic [XLEN-1:0]  o_data
);

  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_keep;
  logic            w_fill;

  always_comb begin
    w_src  = i_data >> {i_off, 3'b000};
    w_keep = '1;
    w_fill = 1'b0;
    case (i_size)
      LSU_SZ_B: begin w_keep = XLEN'(8'hFF);         w_fill = i_sext & w_src[7];  end
      LSU_SZ_H: begin w_keep = XLEN'(16'hFFFF);      w_fill = i_sext & w_src[15]; end
      LSU_SZ_W: begin w_keep = XLEN'(32'hFFFF_FFFF); w_fill = i_sext & w_src[31]; end
      default:  begin w_src  = i_data; end
    endcase
    o_data = (w_src & w_keep) | ({XLEN{w_fill}} & ~w_keep);
  end

endmodule

// File: rtl/core_lsu_rsp_q.sv
// In-order load/store response queue: holds granted transactions until their
// memory response arrives, then hands aligned results to writeback.
module core_lsu_rsp_q
  import core_lsu_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int DEPTH      = 2,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  core_lsu_rsp_q_if.slave       bus,
  input  logic                  flush,
  output logic                  busy,
  output logic                  proto_err
);

  localparam int OFF_W = $clog2(XLEN/8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  lsu_q_entry_t     r_q [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail, r_rptr;
  logic [PTR_W-1:0] w_count;
  logic [DEPTH-1:0] w_live;
  lsu_q_entry_t     w_head_e, w_new;
  logic             w_full, w_undone, w_push, w_rsp_hit;
  logic             w_wb_valid, w_pop, w_drain, w_ok_load, w_trap;
  logic [XLEN-1:0]  w_aligned;

  assign w_count    = r_tail - r_head;
  assign w_full     = (w_count == PTR_W'(DEPTH));
  assign busy       = (w_count != '0);
  // r_rptr walks head->tail: everything behind it is done, everything from it on awaits a response.
  assign w_undone   = (r_rptr != r_tail);
  assign w_push     = bus.req_fire && !w_full;
  assign w_rsp_hit  = bus.rsp_valid && w_undone;
  assign w_head_e   = r_q[r_head[IDX_W-1:0]];
  assign w_wb_valid = busy && w_head_e.done && !w_head_e.kill;
  assign w_drain    = busy && w_head_e.done && w_head_e.kill;
  assign w_pop      = w_wb_valid && bus.wb_ready && !flush;

  always_comb begin
    w_live = '0;
    for (int i = 0; i < DEPTH; i++)
      w_live[i] = ({1'b0, IDX_W'(i) - r_head[IDX_W-1:0]} < w_count);
  end

  always_comb begin
    w_new       = '0;
    w_new.load  = bus.req_load;
    w_new.store = bus.req_store;
    w_new.size  = lsu_size_e'(bus.req_size);
    w_new.sext  = bus.req_sext;
    w_new.rd    = LSU_MAX_RD_W'(bus.req_rd);
    w_new.addr  = LSU_MAX_XLEN'(bus.req_addr);
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_rptr    <= '0;
      proto_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (flush && w_live[i]) r_q[i].kill <= 1'b1;
      if (w_rsp_hit) begin
        r_q[r_rptr[IDX_W-1:0]].done <= 1'b1;
        r_q[r_rptr[IDX_W-1:0]].err  <= bus.rsp_err;
        r_q[r_rptr[IDX_W-1:0]].data <= LSU_MAX_XLEN'(bus.rsp_rdata);
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push) begin
        r_q[r_tail[IDX_W-1:0]] <= w_new;
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop || w_drain) r_head <= r_head + 1'b1;
      if (bus.rsp_valid && !w_undone) proto_err <= 1'b1;
    end
  end

  core_lsu_align #(.XLEN(XLEN)) u_align (
    .i_data (w_head_e.data[XLEN-1:0]),
    .i_off  (w_head_e.addr[OFF_W-1:0]),
    .i_size (w_head_e.size),
    .i_sext (w_head_e.sext),
    .o_data (w_aligned)
  );

  assign w_ok_load     = w_wb_valid && w_head_e.load && !w_head_e.err;
  assign w_trap        = w_wb_valid && w_head_e.err;
  assign bus.req_ready = !w_full;
  assign bus.wb_valid  = w_wb_valid;
  assign bus.wb_rd_wen = w_ok_load;
  assign bus.wb_rd     = w_wb_valid ? w_head_e.rd[REG_ADDR_W-1:0] : '0;
  assign bus.wb_rdata  = w_ok_load ? w_aligned : '0;
  assign bus.wb_trap   = w_trap;
  assign bus.wb_cause  = !w_trap          ? 6'd0 :
                         w_head_e.load    ? TRAP_LDACCESS :
                         w_head_e.store   ? TRAP_STACCESS : 6'd0;
  assign bus.wb_mtval  = w_trap ? w_head_e.addr[XLEN-1:0] : '0;

  a_no_push_when_full: assert property (@(posedge g_clk) disable iff (!g_resetn)
    !(bus.req_fire && w_full));
  a_no_dword_on_rv32: assert property (@(posedge g_clk) disable iff (!g_resetn)
    !(bus.req_fire && bus.req_load && (XLEN == 32) && (bus.req_size == 2'(LSU_SZ_D))));

endmodule

// File: tb/tb_core_lsu_rsp_q.sv
// Directed bench for core_lsu_rsp_q: a 64-bit DEPTH=2 build and a 32-bit
// DEPTH=4 build share clock and reset.
module tb_core_lsu_rsp_q;

  typedef struct {
    logic        load, store;
    logic [1:0]  size;
    logic        sext;
    logic [4:0]  rd;
    logic [63:0] addr, rdata;
    logic        err;
    logic        exp_wen;
    logic [63:0] exp_rdata;
    logic        exp_trap;
    logic [5:0]  exp_cause;
    logic [63:0] exp_mtval;
  } vec_t;

  logic g_clk, g_resetn;
  logic flush64, busy64, perr64;
  logic flush32, busy32, perr32;
  int   n_checks = 0;
  int   n_errs   = 0;
  logic [63:0] exp_q[$];
  vec_t vecs[11];

  core_lsu_rsp_q_if #(.XLEN(64), .REG_ADDR_W(5)) b64 ();
  core_lsu_rsp_q_if #(.XLEN(32), .REG_ADDR_W(5)) b32 ();

  core_lsu_rsp_q #(.XLEN(64), .DEPTH(2), .REG_ADDR_W(5)) u_dut64 (
    .g_clk(g_clk), .g_resetn(g_resetn), .bus(b64),
    .flush(flush64), .busy(busy64), .proto_err(perr64)
  );
  core_lsu_rsp_q #(.XLEN(32), .DEPTH(4), .REG_ADDR_W(5)) u_dut32 (
    .g_clk(g_clk), .g_resetn(g_resetn), .bus(b32),
    .flush(flush32), .busy(busy32), .proto_err(perr32)
  );

  // clock / reset
  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic tick();
    @(posedge g_clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // drivers
  task automatic push64(input logic ld, input logic st, input logic [1:0] sz,
                        input logic sx, input logic [4:0] rd, input logic [63:0] ad);
    b64.req_fire = 1'b1; b64.req_load = ld; b64.req_store = st;
    b64.req_size = sz;   b64.req_sext = sx; b64.req_rd = rd; b64.req_addr = ad;
    tick();
    b64.req_fire = 1'b0;
  endtask

  task automatic push32(input logic [1:0] sz, input logic sx, input logic [4:0] rd,
                        input logic [31:0] ad);
    b32.req_fire = 1'b1; b32.req_load = 1'b1; b32.req_store = 1'b0;
    b32.req_size = sz;   b32.req_sext = sx;   b32.req_rd = rd; b32.req_addr = ad;
    tick();
    b32.req_fire = 1'b0;
  endtask

  task automatic rsp64(input logic [63:0] d);
    b64.rsp_valid = 1'b1; b64.rsp_err = 1'b0; b64.rsp_rdata = d;
  endtask

  task automatic rsp32(input logic [31:0] d);
    b32.rsp_valid = 1'b1; b32.rsp_err = 1'b0; b32.rsp_rdata = d;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    push64(v.load, v.store, v.size, v.sext, v.rd, v.addr);
    b64.rsp_valid = 1'b1; b64.rsp_err = v.err; b64.rsp_rdata = v.rdata;
    #1;
    chk($sformatf("v%0d same-cycle wb_valid", k), b64.wb_valid, 0);
    tick();
    b64.rsp_valid = 1'b0; b64.rsp_err = 1'b0;
    chk($sformatf("v%0d wb_valid", k), b64.wb_valid, 1);
    chk($sformatf("v%0d wb_rd_wen", k), b64.wb_rd_wen, v.exp_wen);
    chk($sformatf("v%0d wb_rd", k), b64.wb_rd, v.rd);
    chk($sformatf("v%0d wb_rdata", k), b64.wb_rdata, v.exp_rdata);
    chk($sformatf("v%0d wb_trap", k), b64.wb_trap, v.exp_trap);
    chk($sformatf("v%0d wb_cause", k), b64.wb_cause, v.exp_cause);
    chk($sformatf("v%0d wb_mtval", k), b64.wb_mtval, v.exp_mtval);
    b64.wb_ready = 1'b1;
    tick();
    b64.wb_ready = 1'b0;
    chk($sformatf("v%0d busy after pop", k), busy64, 0);
    chk($sformatf("v%0d wb_valid after pop", k), b64.wb_valid, 0);
  endtask

  initial begin
    //          ld st sz sx rd  addr                   rdata                  err wen exp_rdata              trp cause mtval
    vecs[0]  = '{1, 0, 0, 1, 5,  64'h3,                 64'h0000_0000_8000_0000, 0, 1, 64'hFFFF_FFFF_FFFF_FF80, 0, 0, 64'h0};
    vecs[1]  = '{1, 0, 0, 0, 5,  64'h3,                 64'h0000_0000_8000_0000, 0, 1, 64'h0000_0000_0000_0080, 0, 0, 64'h0};
    vecs[2]  = '{1, 0, 1, 1, 6,  64'h6,                 64'h8001_0000_0000_0000, 0, 1, 64'hFFFF_FFFF_FFFF_8001, 0, 0, 64'h0};
    vecs[3]  = '{1, 0, 2, 1, 7,  64'h4,                 64'h1234_5678_0000_0000, 0, 1, 64'h0000_0000_1234_5678, 0, 0, 64'h0};
    vecs[4]  = '{1, 0, 2, 1, 8,  64'hC,                 64'hDEAD_BEEF_0000_0000, 0, 1, 64'hFFFF_FFFF_DEAD_BEEF, 0, 0, 64'h0};
    vecs[5]  = '{1, 0, 2, 0, 8,  64'h4,                 64'hDEAD_BEEF_0000_0000, 0, 1, 64'h0000_0000_DEAD_BEEF, 0, 0, 64'h0};
    vecs[6]  = '{1, 0, 3, 1, 9,  64'h8,                 64'h8123_4567_89AB_CDEF, 0, 1, 64'h8123_4567_89AB_CDEF, 0, 0, 64'h0};
    vecs[7]  = '{1, 0, 0, 0, 10, 64'hF,                 64'hAB00_0000_0000_0000, 0, 1, 64'h0000_0000_0000_00AB, 0, 0, 64'h0};
    vecs[8]  = '{0, 1, 2, 0, 0,  64'h1000,              64'h0,                   1, 0, 64'h0,                   1, 7, 64'h1000};
    vecs[9]  = '{1, 0, 2, 1, 11, 64'h2004,              64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 64'h0,                   1, 5, 64'h2004};
    vecs[10] = '{0, 1, 3, 0, 0,  64'h3000,              64'h0,                   0, 0, 64'h0,                   0, 0, 64'h0};

    g_resetn = 1'b0;
    flush64 = 1'b0; flush32 = 1'b0;
    b64.req_fire = 0; b64.req_load = 0; b64.req_store = 0; b64.req_size = 0;
    b64.req_sext = 0; b64.req_rd = 0; b64.req_addr = 0;
    b64.rsp_valid = 0; b64.rsp_err = 0; b64.rsp_rdata = 0; b64.wb_ready = 0;
    b32.req_fire = 0; b32.req_load = 0; b32.req_store = 0; b32.req_size = 0;
    b32.req_sext = 0; b32.req_rd = 0; b32.req_addr = 0;
    b32.rsp_valid = 0; b32.rsp_err = 0; b32.rsp_rdata = 0; b32.wb_ready = 0;
    tick(); tick();
    g_resetn = 1'b1;

    // reset state
    chk("rst wb_valid", b64.wb_valid, 0);
    chk("rst wb_rd_wen", b64.wb_rd_wen, 0);
    chk("rst wb_trap", b64.wb_trap, 0);
    chk("rst wb_cause", b64.wb_cause, 0);
    chk("rst wb_rdata", b64.wb_rdata, 0);
    chk("rst wb_mtval", b64.wb_mtval, 0);
    chk("rst busy", busy64, 0);
    chk("rst req_ready", b64.req_ready, 1);
    chk("rst proto_err", perr64, 0);
    chk("rst32 wb_valid", b32.wb_valid, 0);
    chk("rst32 req_ready", b32.req_ready, 1);

    // single transactions from the table
    for (int k = 0; k < 11; k++) run_vec(vecs[k], k);

    // fill to DEPTH, responses back to back, writeback stalled
    push64(1, 0, 2, 0, 1, 64'h10);
    exp_q.push_back(64'h0000_0000_1111_2222);
    chk("full busy after one", busy64, 1);
    chk("full ready after one", b64.req_ready, 1);
    push64(1, 0, 1, 1, 2, 64'h22);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_F00D);
    chk("full req_ready", b64.req_ready, 0);
    rsp64(64'h9999_8888_1111_2222);
    tick();
    rsp64(64'h0000_0000_F00D_0000);
    chk("full r0 wb_valid", b64.wb_valid, 1);
    chk("full r0 wb_rd", b64.wb_rd, 1);
    chk("full r0 wb_rdata", b64.wb_rdata, exp_q[0]);
    tick();
    b64.rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d wb_valid", c), b64.wb_valid, 1);
      chk($sformatf("stall%0d wb_rd", c), b64.wb_rd, 1);
      chk($sformatf("stall%0d wb_rdata", c), b64.wb_rdata, exp_q[0]);
      chk($sformatf("stall%0d req_ready", c), b64.req_ready, 0);
      tick();
    end
    b64.wb_ready = 1'b1;
    tick();
    b64.wb_ready = 1'b0;
    void'(exp_q.pop_front());
    chk("r1 req_ready back", b64.req_ready, 1);
    chk("r1 wb_valid", b64.wb_valid, 1);
    chk("r1 wb_rd", b64.wb_rd, 2);
    chk("r1 wb_rdata", b64.wb_rdata, exp_q[0]);
    b64.wb_ready = 1'b1;
    tick();
    b64.wb_ready = 1'b0;
    void'(exp_q.pop_front());
    chk("r1 busy after pop", busy64, 0);
    chk("scoreboard empty", exp_q.size(), 0);

    // response with nothing pending
    chk("proto_err clean", perr64, 0);
    rsp64(64'h55);
    tick();
    b64.rsp_valid = 1'b0;
    chk("proto_err set", perr64, 1);
    chk("proto wb_valid", b64.wb_valid, 0);
    chk("proto busy", busy64, 0);
    tick(); tick();
    chk("proto_err sticky", perr64, 1);

    // flush with two pending, third pushed in the flush cycle (32-bit, DEPTH=4)
    push32(2, 0, 3, 32'h0);
    push32(2, 0, 4, 32'h4);
    flush32 = 1'b1;
    push32(0, 0, 5, 32'h1);
    flush32 = 1'b0;
    chk("flush busy", busy32, 1);
    rsp32(32'hFFFF_FFFF);
    #1 chk("flush d0 wb_valid", b32.wb_valid, 0);
    tick();
    rsp32(32'h8000_0001);
    chk("flush d1 wb_valid", b32.wb_valid, 0);
    tick();
    rsp32(32'h0000_5A00);
    chk("flush d2 wb_valid", b32.wb_valid, 0);
    tick();
    b32.rsp_valid = 1'b0;
    chk("flush live wb_valid", b32.wb_valid, 1);
    chk("flush live wb_rd", b32.wb_rd, 5);
    chk("flush live wb_rdata", b32.wb_rdata, 32'h0000_005A);
    chk("flush live wb_rd_wen", b32.wb_rd_wen, 1);
    b32.wb_ready = 1'b1;
    tick();
    b32.wb_ready = 1'b0;
    chk("flush busy after pop", busy32, 0);
    chk("flush proto_err", perr32, 0);

    // 32-bit halfword at offset 2, then reset with the result pending
    push32(1, 1, 7, 32'h102);
    rsp32(32'hBEEF_0000);
    tick();
    b32.rsp_valid = 1'b0;
    chk("rv32 lh wb_valid", b32.wb_valid, 1);
    chk("rv32 lh wb_rdata", b32.wb_rdata, 32'hFFFF_BEEF);
    push32(2, 0, 8, 32'h200);
    g_resetn = 1'b0;
    tick();
    chk("midrst busy", busy32, 0);
    chk("midrst wb_valid", b32.wb_valid, 0);
    chk("midrst req_ready", b32.req_ready, 1);
    chk("midrst proto_err64", perr64, 0);
    g_resetn = 1'b1;
    tick();
    chk("postrst busy", busy32, 0);

    // report
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
